// File: rtl/data_mem_ctrl.sv
// Data-side memory controller: word-addressed 64-bit RAM with fixed access latency,
// one-cycle d_Ready completion pulse and d_Error flagging of illegal requests.
module data_mem_ctrl #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2,
    parameter logic [63:0] BASE_ADDR   = 64'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] d_address,
    input  logic [63:0] d_WriteData,
    input  logic        d_MemWrite,
    input  logic        d_MemRead,
    output logic [63:0] d_ReadData,
    output logic        d_Ready,
    output logic        d_Error
);

    localparam int unsigned AW       = $clog2(DEPTH_WORDS);
    localparam logic [63:0] SPAN     = 64'(DEPTH_WORDS) << 3;
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic [63:0]     wdata_q, wdata_d;
    logic            wr_q, wr_d;
    logic            rd_q, rd_d;
    logic            err_q, err_d;
    logic [63:0]     rdata_q, rdata_d;
    logic            ready_q, ready_d;
    logic            error_q, error_d;

    logic [63:0]     mem [DEPTH_WORDS];

    logic [63:0]     bus_off;
    logic [AW-1:0]   bus_idx;
    logic            bus_err;
    logic            done_entry;
    logic            cur_wr, cur_rd, cur_err;
    logic [AW-1:0]   cur_idx;
    logic [63:0]     cur_wdata;
    logic            mem_we;

    always_comb begin
        // Offset compare avoids overflow of BASE_ADDR+SPAN near the top of the address space
        bus_off = d_address - BASE_ADDR;
        bus_idx = bus_off[AW+2:3];
        bus_err = (d_address[2:0] != 3'b000) || (d_address < BASE_ADDR) ||
                  (bus_off >= SPAN) || (d_MemRead && d_MemWrite);

        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        ready_d    = 1'b0;
        error_d    = 1'b0;
        done_entry = 1'b0;
        cur_wr     = wr_q;
        cur_rd     = rd_q;
        cur_err    = err_q;
        cur_idx    = idx_q;
        cur_wdata  = wdata_q;

        case (state_q)
            IDLE: begin
                if (d_MemRead || d_MemWrite) begin
                    idx_d     = bus_idx;
                    wdata_d   = d_WriteData;
                    wr_d      = d_MemWrite;
                    rd_d      = d_MemRead;
                    err_d     = bus_err;
                    cnt_d     = CNT_INIT;
                    // With LATENCY==1 the acceptance edge is also the commit edge
                    cur_wr    = d_MemWrite;
                    cur_rd    = d_MemRead;
                    cur_err   = bus_err;
                    cur_idx   = bus_idx;
                    cur_wdata = d_WriteData;
                    if (LATENCY == 1) begin
                        state_d    = DONE;
                        done_entry = 1'b1;
                    end else begin
                        state_d = BUSY;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d    = DONE;
                    done_entry = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (done_entry) begin
            ready_d = 1'b1;
            error_d = cur_err;
            if (cur_err) begin
                rdata_d = '0;
            end else if (cur_rd) begin
                rdata_d = mem[cur_idx];
            end
        end
        mem_we = done_entry && cur_wr && !cur_err;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            ready_q <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            error_q <= error_d;
            if (mem_we) begin
                mem[cur_idx] <= cur_wdata;
            end
        end
    end

    assign d_ReadData = rdata_q;
    assign d_Ready    = ready_q;
    assign d_Error    = error_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl: four instances at LATENCY 2, 1, 5 and 4,
// each with its own bus and reset, checked with immediate assertions.
module tb_data_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst   [4];
    logic [63:0] addr  [4];
    logic [63:0] wdata [4];
    logic        we    [4];
    logic        re    [4];
    logic [63:0] rdata [4];
    logic        rdy   [4];
    logic        err   [4];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(2), .BASE_ADDR(64'h0)) u_l2 (
        .clk(clk), .reset(rst[0]), .d_address(addr[0]), .d_WriteData(wdata[0]),
        .d_MemWrite(we[0]), .d_MemRead(re[0]), .d_ReadData(rdata[0]),
        .d_Ready(rdy[0]), .d_Error(err[0]));
    data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(64'h0)) u_l1 (
        .clk(clk), .reset(rst[1]), .d_address(addr[1]), .d_WriteData(wdata[1]),
        .d_MemWrite(we[1]), .d_MemRead(re[1]), .d_ReadData(rdata[1]),
        .d_Ready(rdy[1]), .d_Error(err[1]));
    data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(5), .BASE_ADDR(64'h0)) u_l5 (
        .clk(clk), .reset(rst[2]), .d_address(addr[2]), .d_WriteData(wdata[2]),
        .d_MemWrite(we[2]), .d_MemRead(re[2]), .d_ReadData(rdata[2]),
        .d_Ready(rdy[2]), .d_Error(err[2]));
    data_mem_ctrl #(.DEPTH_WORDS(256), .LATENCY(4), .BASE_ADDR(64'h0)) u_l4 (
        .clk(clk), .reset(rst[3]), .d_address(addr[3]), .d_WriteData(wdata[3]),
        .d_MemWrite(we[3]), .d_MemRead(re[3]), .d_ReadData(rdata[3]),
        .d_Ready(rdy[3]), .d_Error(err[3]));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_bus(input int k);
        addr[k] = '0; wdata[k] = '0; we[k] = 1'b0; re[k] = 1'b0;
    endtask

    // One transaction on instance k; returns cycles from acceptance to d_Ready (-1 on timeout)
    // and the outputs seen in the d_Ready cycle. Optionally scrambles the bus while busy.
    task automatic xact(input int k, input logic rd, input logic wr, input logic [63:0] a,
                        input logic [63:0] wd, input logic scramble,
                        output int lat, output logic e, output logic [63:0] rdv);
        lat = -1; e = 1'b0; rdv = '0;
        @(negedge clk);
        addr[k] = a; wdata[k] = wd; re[k] = rd; we[k] = wr;
        @(posedge clk);
        #1;
        for (int n = 1; n <= 30; n++) begin
            if (scramble) begin
                addr[k] = {$urandom, $urandom}; wdata[k] = {$urandom, $urandom};
                re[k] = 1'($urandom); we[k] = 1'($urandom);
            end else begin
                idle_bus(k);
            end
            @(negedge clk);
            if (rdy[k] === 1'b1) begin
                lat = n; e = err[k]; rdv = rdata[k];
                break;
            end
        end
        idle_bus(k);
        @(negedge clk);
        chk("ready_one_cycle", 64'(rdy[k]), 64'(0));
    endtask

    int          lat;
    logic        e;
    logic [63:0] rv;
    int          pulses;
    logic [12:0] mask;

    initial begin
        for (int k = 0; k < 4; k++) begin
            rst[k] = 1'b1;
            addr[k] = {$urandom, $urandom}; wdata[k] = {$urandom, $urandom};
            re[k] = 1'($urandom); we[k] = 1'($urandom);
        end
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("reset_ready", 64'(rdy[k]), 64'(0));
            chk("reset_error", 64'(err[k]), 64'(0));
            chk("reset_rdata", rdata[k], 64'h0);
            idle_bus(k);
            rst[k] = 1'b0;
        end

        // LATENCY=2 write/read
        xact(0, 1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 1'b0, lat, e, rv);
        chk("l2_wr_lat", 64'(lat), 64'd2);
        chk("l2_wr_err", 64'(e), 64'd0);
        chk("l2_wr_rdata_unchanged", rv, 64'h0);
        xact(0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, lat, e, rv);
        chk("l2_rd_lat", 64'(lat), 64'd2);
        chk("l2_rd_err", 64'(e), 64'd0);
        chk("l2_rd_data", rv, 64'hDEADBEEF_CAFEF00D);
        repeat (3) @(negedge clk);
        chk("l2_rd_hold", rdata[0], 64'hDEADBEEF_CAFEF00D);

        // Latency sweep with bus scrambled while busy
        xact(1, 1'b0, 1'b1, 64'h08, 64'h1111_2222_3333_4444, 1'b1, lat, e, rv);
        chk("l1_wr_lat", 64'(lat), 64'd1);
        xact(1, 1'b1, 1'b0, 64'h08, 64'h0, 1'b1, lat, e, rv);
        chk("l1_rd_lat", 64'(lat), 64'd1);
        chk("l1_rd_data", rv, 64'h1111_2222_3333_4444);
        xact(2, 1'b0, 1'b1, 64'h28, 64'h5555_6666_7777_8888, 1'b1, lat, e, rv);
        chk("l5_wr_lat", 64'(lat), 64'd5);
        chk("l5_wr_err", 64'(e), 64'd0);
        xact(2, 1'b1, 1'b0, 64'h28, 64'h0, 1'b1, lat, e, rv);
        chk("l5_rd_lat", 64'(lat), 64'd5);
        chk("l5_rd_data", rv, 64'h5555_6666_7777_8888);

        // Illegal accesses
        xact(0, 1'b1, 1'b0, 64'h0C, 64'h0, 1'b0, lat, e, rv);
        chk("misalign_lat", 64'(lat), 64'd2);
        chk("misalign_err", 64'(e), 64'd1);
        chk("misalign_rdata", rv, 64'h0);
        xact(0, 1'b0, 1'b1, 64'h0, 64'h5, 1'b0, lat, e, rv);
        chk("base_wr_err", 64'(e), 64'd0);
        xact(0, 1'b0, 1'b1, 64'h800, 64'hBAD, 1'b0, lat, e, rv);
        chk("oor_wr_err", 64'(e), 64'd1);
        xact(0, 1'b1, 1'b0, 64'h0, 64'h0, 1'b0, lat, e, rv);
        chk("oor_no_alias", rv, 64'h5);
        chk("oor_no_alias_err", 64'(e), 64'd0);
        xact(0, 1'b0, 1'b1, 64'h7F8, 64'hFEED, 1'b0, lat, e, rv);
        chk("top_word_wr_err", 64'(e), 64'd0);
        xact(0, 1'b1, 1'b0, 64'h7F8, 64'h0, 1'b0, lat, e, rv);
        chk("top_word_rd", rv, 64'hFEED);
        xact(0, 1'b1, 1'b1, 64'h10, 64'h77, 1'b0, lat, e, rv);
        chk("both_err", 64'(e), 64'd1);
        chk("both_rdata", rv, 64'h0);
        xact(0, 1'b1, 1'b0, 64'h10, 64'h0, 1'b0, lat, e, rv);
        chk("both_no_write", rv, 64'hDEADBEEF_CAFEF00D);

        // Reset mid-operation on LATENCY=4
        xact(3, 1'b0, 1'b1, 64'h20, 64'h1234, 1'b0, lat, e, rv);
        chk("l4_wr_lat", 64'(lat), 64'd4);
        @(negedge clk);
        addr[3] = 64'h20; wdata[3] = 64'h1; we[3] = 1'b1;
        @(posedge clk);
        #1;
        idle_bus(3);
        @(negedge clk);
        pulses = 0;
        if (rdy[3] === 1'b1) pulses++;
        @(negedge clk);
        rst[3] = 1'b1;
        if (rdy[3] === 1'b1) pulses++;
        @(negedge clk);
        rst[3] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (rdy[3] === 1'b1) pulses++;
            @(negedge clk);
        end
        chk("abort_no_ready", 64'(pulses), 64'd0);
        xact(3, 1'b1, 1'b0, 64'h20, 64'h0, 1'b0, lat, e, rv);
        chk("abort_no_commit", rv, 64'h1234);

        // Held request on LATENCY=2
        xact(0, 1'b0, 1'b1, 64'h18, 64'h5151, 1'b0, lat, e, rv);
        @(negedge clk);
        addr[0] = 64'h18; re[0] = 1'b1;
        mask = '0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 10) idle_bus(0);
            mask[i] = rdy[0];
        end
        chk("held_pulses", 64'(mask), 64'(13'b0_1001_0010_0100));
        chk("held_rdata", rdata[0], 64'h5151);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
